// File: rtl/key_evt_pkg.sv
// Shared types and 12 MHz default timing constants for the key event classifier.
package key_evt_pkg;

  localparam int unsigned CNT_W_DFLT     = 24;
  localparam int unsigned LONG_CYC_12M   = 12_000_000;
  localparam int unsigned DBL_CYC_12M    = 3_600_000;
  localparam int unsigned REPEAT_CYC_12M = 2_400_000;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPress1 = 3'd1,
    StWait2  = 3'd2,
    StPress2 = 3'd3,
    StHold   = 3'd4
  } key_state_e;

endpackage

// File: rtl/key_event_classifier_if.sv
// Key inputs from the debouncer and gesture event outputs to the application.
interface key_event_classifier_if;

  logic key_pulse;
  logic key_level;
  logic single_click;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  modport master (
    output key_pulse,
    output key_level,
    input  single_click,
    input  double_click,
    input  long_press,
    input  repeat_pulse,
    input  busy
  );

  modport slave (
    input  key_pulse,
    input  key_level,
    output single_click,
    output double_click,
    output long_press,
    output repeat_pulse,
    output busy
  );

endinterface

// File: rtl/key_evt_timer.sv
// Saturating gesture timer; o_tc flags when the count equals the selected terminal value.
module key_evt_timer
  import key_evt_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key gestures into single click, double click and long press pulses.
// Optional auto-repeat while held after a long press is enabled by defining KEY_REPEAT_EN.
module key_event_classifier
  import key_evt_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DFLT,
  parameter int unsigned LONG_CYC   = LONG_CYC_12M,
  parameter int unsigned DBL_CYC    = DBL_CYC_12M,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_12M
) (
  input logic                   clk,
  input logic                   rst,
  key_event_classifier_if.slave key_bus
);

  localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

  if ((64'(LONG_CYC) - 64'd1) > CntMax || (64'(DBL_CYC) - 64'd1) > CntMax ||
      (64'(REPEAT_CYC) - 64'd1) > CntMax) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured cycle counts");
  end

  key_state_e       r_state;
  logic             r_single;
  logic             r_double;
  logic             r_long;
  logic             r_repeat;
  logic             r_busy;

  logic [CNT_W-1:0] w_term;
  logic             w_timed;
  logic             w_leave;
  logic             w_clr;
  logic             w_tc;

  // One timer shared by all timed states; the terminal value follows the current state.
  always_comb begin
    w_term  = '0;
    w_timed = 1'b0;
    unique case (r_state)
      StPress1: begin
        w_term  = CNT_W'(LONG_CYC - 1);
        w_timed = 1'b1;
      end
      StWait2: begin
        w_term  = CNT_W'(DBL_CYC - 1);
        w_timed = 1'b1;
      end
`ifdef KEY_REPEAT_EN
      StHold: begin
        w_term  = CNT_W'(REPEAT_CYC - 1);
        w_timed = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Any state exit (or repeat wrap) restarts the timer from zero.
  always_comb begin
    w_leave = 1'b0;
    unique case (r_state)
      StPress1: w_leave = key_bus.key_level | w_tc;
      StWait2:  w_leave = key_bus.key_pulse | w_tc;
`ifdef KEY_REPEAT_EN
      StHold:   w_leave = key_bus.key_level | w_tc;
`endif
      default:  w_leave = 1'b0;
    endcase
  end

  assign w_clr = ~w_timed | w_leave;

  key_evt_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_timed),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (key_bus.key_pulse) begin
            r_state <= StPress1;
            r_busy  <= 1'b1;
          end
        end
        StPress1: begin
          // Release wins over a coincident long-press timeout.
          if (key_bus.key_level) begin
            r_state <= StWait2;
          end else if (w_tc) begin
            r_long  <= 1'b1;
            r_state <= StHold;
          end
        end
        StWait2: begin
          if (key_bus.key_pulse) begin
            r_state <= StPress2;
          end else if (w_tc) begin
            r_single <= 1'b1;
            r_state  <= StIdle;
            r_busy   <= 1'b0;
          end
        end
        StPress2: begin
          if (key_bus.key_level) begin
            r_double <= 1'b1;
            r_state  <= StIdle;
            r_busy   <= 1'b0;
          end
        end
        StHold: begin
          if (key_bus.key_level) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
`ifdef KEY_REPEAT_EN
          else if (w_tc) begin
            r_repeat <= 1'b1;
          end
`endif
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign key_bus.single_click = r_single;
  assign key_bus.double_click = r_double;
  assign key_bus.long_press   = r_long;
`ifdef KEY_REPEAT_EN
  assign key_bus.repeat_pulse = r_repeat;
`else
  assign key_bus.repeat_pulse = 1'b0;
`endif
  assign key_bus.busy         = r_busy;

endmodule

// File: tb/tb_key_event_classifier.sv
// Scoreboard bench for key_event_classifier: expected events are queued when stimulus is
// driven and matched by kind and cycle when the DUT pulses.
module tb_key_event_classifier;

  localparam int unsigned CntW    = 8;
  localparam int unsigned LongCyc = 100;
  localparam int unsigned DblCyc  = 40;
  localparam int unsigned RepCyc  = 20;

  localparam int EvSingle = 1;
  localparam int EvDouble = 2;
  localparam int EvLong   = 3;
  localparam int EvRepeat = 4;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  sb_q[$];

  key_event_classifier_if u_if ();

  key_event_classifier #(
    .CNT_W      (CntW),
    .LONG_CYC   (LongCyc),
    .DBL_CYC    (DblCyc),
    .REPEAT_CYC (RepCyc)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_bus (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    sb_q.push_back(e);
  endtask

  // Repeats fall every RepCyc cycles after HOLD entry, strictly before the release edge.
  task automatic push_repeats(input int hold_at, input int rel_edge);
`ifdef KEY_REPEAT_EN
    for (int t = hold_at + int'(RepCyc); t < rel_edge; t += int'(RepCyc)) begin
      push_ev(EvRepeat, t);
    end
`else
    if (hold_at > rel_edge) push_ev(EvRepeat, 0);
`endif
  endtask

  always @(negedge clk) begin : mon
    int  n;
    int  kind;
    ev_t e;
    n    = 0;
    kind = 0;
    if (u_if.single_click === 1'b1) begin n++; kind = EvSingle; end
    if (u_if.double_click === 1'b1) begin n++; kind = EvDouble; end
    if (u_if.long_press   === 1'b1) begin n++; kind = EvLong;   end
    if (u_if.repeat_pulse === 1'b1) begin n++; kind = EvRepeat; end
    if (n != 0) begin
      check_val("onehot", n, 1);
      if (sb_q.size() == 0) begin
        check_val("spurious_event", kind, 0);
      end else begin
        e = sb_q.pop_front();
        check_val("event_kind", kind, e.kind);
        check_val("event_cycle", cyc, e.at);
        if (kind == EvSingle || kind == EvDouble) check_val("busy_at_end", u_if.busy, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    u_if.key_pulse = 1'b1;
    u_if.key_level = 1'b0;
    tick(1);
    u_if.key_pulse = 1'b0;
  endtask

  task automatic drain(input string tag);
    tick(60);
    check_val(tag, sb_q.size(), 0);
    check_val({tag, "_busy"}, u_if.busy, 0);
    sb_q.delete();
  endtask

  initial begin
    int n;
    int k;
    u_if.key_pulse = 1'b0;
    u_if.key_level = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_val("rst_single", u_if.single_click, 0);
    check_val("rst_double", u_if.double_click, 0);
    check_val("rst_long", u_if.long_press, 0);
    check_val("rst_repeat", u_if.repeat_pulse, 0);
    check_val("rst_busy", u_if.busy, 0);
    tick(3);
    rst = 1'b1;
    tick(2);

    // Single click: 10 cycles low, single_click 41 cycles after the release is driven.
    press();
    check_val("busy_press", u_if.busy, 1);
    tick(9);
    k = cyc;
    u_if.key_level = 1'b1;
    push_ev(EvSingle, k + 41);
    drain("drain_single");

    // Double click with a 15-cycle gap.
    press();
    tick(9);
    u_if.key_level = 1'b1;
    tick(15);
    press();
    tick(9);
    k = cyc;
    u_if.key_level = 1'b1;
    push_ev(EvDouble, k + 1);
    drain("drain_double");

    // Long press held 150 cycles.
    n = cyc;
    press();
    push_ev(EvLong, n + 101);
    tick(149);
    u_if.key_level = 1'b1;
    push_repeats(n + 101, n + 151);
    drain("drain_long150");

    // Long press held 205 cycles: five repeats when enabled.
    n = cyc;
    press();
    push_ev(EvLong, n + 101);
    tick(204);
    u_if.key_level = 1'b1;
    push_repeats(n + 101, n + 206);
    drain("drain_long205");

    // Release coincident with a repeat terminal count.
    n = cyc;
    press();
    push_ev(EvLong, n + 101);
    tick(139);
    u_if.key_level = 1'b1;
    push_repeats(n + 101, n + 141);
    drain("drain_rep_edge");

    // Release coincident with cnt==99 in PRESS1: no long press, single click follows.
    press();
    tick(99);
    k = cyc;
    u_if.key_level = 1'b1;
    push_ev(EvSingle, k + 41);
    drain("drain_long_edge");

    // Second press coincident with cnt==39 in WAIT2: double path wins.
    press();
    tick(9);
    u_if.key_level = 1'b1;
    tick(40);
    press();
    tick(4);
    k = cyc;
    u_if.key_level = 1'b1;
    push_ev(EvDouble, k + 1);
    drain("drain_dbl_edge");

    // Level glitch in IDLE without a pulse is ignored.
    u_if.key_level = 1'b0;
    tick(5);
    check_val("glitch_busy", u_if.busy, 0);
    u_if.key_level = 1'b1;
    drain("drain_glitch");

    // Reset in WAIT2 at cnt==20: everything drops immediately, nothing after release.
    press();
    tick(9);
    u_if.key_level = 1'b1;
    tick(21);
    check_val("pre_rst_busy", u_if.busy, 1);
    rst = 1'b0;
    #1;
    check_val("mid_rst_busy", u_if.busy, 0);
    check_val("mid_rst_single", u_if.single_click, 0);
    check_val("mid_rst_double", u_if.double_click, 0);
    check_val("mid_rst_long", u_if.long_press, 0);
    check_val("mid_rst_state", int'(dut.r_state), 0);
    tick(3);
    rst = 1'b1;
    tick(20);
    drain("drain_reset");

    check_val("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
